// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Constants and helpers shared by the ID-stage hazard logic
//                and the EX-stage forwarding logic.
//                - ZeroReg          : hard-wired zero register address
//                - RUN / MEM_WAIT   : stall-unit FSM encoding
//                - FWD_SEL_*        : forwarding-mux select encodings
//                - reg_match()      : source-operand match against a dest
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam logic [4:0] ZeroReg = 5'b00000;

    localparam int         STATE_W  = 1;
    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] MEM_WAIT = 1'b1;

    // Operand-select encodings used by the EX-stage forwarding mux.
    localparam logic [1:0] FWD_SEL_REG   = 2'b00;
    localparam logic [1:0] FWD_SEL_MEMWB = 2'b01;
    localparam logic [1:0] FWD_SEL_EXMEM = 2'b10;

    // A destination matches the ID instruction when it is a real register and
    // equals rs, or equals rt while rt is actually read as a source.
    function automatic logic reg_match(input logic [4:0] dest,
                                       input logic [4:0] rs,
                                       input logic [4:0] rt,
                                       input logic       uses_rt);
        return (dest != ZeroReg) && ((dest == rs) || (uses_rt && (dest == rt)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_detect
//  Description : Combinational detection of hazards that bypassing cannot
//                cover: load-use, and branch operands produced by an
//                instruction still in EX (any writer) or MEM (loads only).
//  Ports       : i_rs/i_rt/i_uses_rt/i_branch - ID instruction sources
//                i_ex_memread/i_ex_regwrite/i_ex_rd - EX instruction
//                i_mem_memread/i_mem_rd            - MEM instruction
//                o_hz                               - stall ID this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
    import cpu_pkg::*;
(
    input  logic [4:0] i_rs,
    input  logic [4:0] i_rt,
    input  logic       i_uses_rt,
    input  logic       i_branch,
    input  logic       i_ex_memread,
    input  logic       i_ex_regwrite,
    input  logic [4:0] i_ex_rd,
    input  logic       i_mem_memread,
    input  logic [4:0] i_mem_rd,
    output logic       o_hz
);

    logic w_ex_match;
    logic w_mem_match;

    assign w_ex_match  = reg_match(i_ex_rd,  i_rs, i_rt, i_uses_rt);
    assign w_mem_match = reg_match(i_mem_rd, i_rs, i_rt, i_uses_rt);

    // Branches compare in ID, so they need the value one stage earlier than
    // ALU consumers: an ALU result in EX stalls one cycle, a load stalls until
    // it has left MEM.
    assign o_hz = (i_ex_memread && w_ex_match)
               || (i_branch && ((i_ex_regwrite && w_ex_match)
                             || (i_mem_memread && w_mem_match)));

endmodule
`default_nettype wire

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_unit
//  Description : Pipeline stall/flush/freeze control. Stalls IF/ID with an
//                ID/EX bubble on unresolvable data hazards, flushes IF/ID on
//                taken branches and jumps, and freezes the pipeline while a
//                data-memory access in MEM waits for its acknowledge.
//  Ports       : clk_i, rst_i (async, active-low)
//                IF_ID_* / ID_EX_* / EX_MEM_* - stage information
//                Branch_taken_i, Jump_i, dmem_ack_i
//                PC_Write_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_Bubble_o,
//                Pipe_Hold_o, MEM_WB_Bubble_o, dmem_req_o,
//                stall_cnt_o (saturating), err_o (sticky timeout)
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_unit
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  IF_ID_RsAddr_i,
    input  logic [4:0]  IF_ID_RtAddr_i,
    input  logic        IF_ID_UsesRt_i,
    input  logic        IF_ID_Branch_i,
    input  logic        Branch_taken_i,
    input  logic        Jump_i,
    input  logic        ID_EX_MemRead_i,
    input  logic        ID_EX_RegWrite_i,
    input  logic [4:0]  ID_EX_RdAddr_i,
    input  logic        EX_MEM_MemRead_i,
    input  logic        EX_MEM_MemAccess_i,
    input  logic [4:0]  EX_MEM_RdAddr_i,
    input  logic        dmem_ack_i,
    output logic        PC_Write_o,
    output logic        IF_ID_Write_o,
    output logic        IF_ID_Flush_o,
    output logic        ID_EX_Bubble_o,
    output logic        Pipe_Hold_o,
    output logic        MEM_WB_Bubble_o,
    output logic        dmem_req_o,
    output logic [15:0] stall_cnt_o,
    output logic        err_o
);

    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;
    logic [7:0]         r_wait_cnt;
    logic [15:0]        r_stall_cnt;
    logic               r_err;
    logic               w_hz;
    logic               w_hold;
    logic               w_req;

    hazard_detect u_hazard_detect (
        .i_rs          (IF_ID_RsAddr_i),
        .i_rt          (IF_ID_RtAddr_i),
        .i_uses_rt     (IF_ID_UsesRt_i),
        .i_branch      (IF_ID_Branch_i),
        .i_ex_memread  (ID_EX_MemRead_i),
        .i_ex_regwrite (ID_EX_RegWrite_i),
        .i_ex_rd       (ID_EX_RdAddr_i),
        .i_mem_memread (EX_MEM_MemRead_i),
        .i_mem_rd      (EX_MEM_RdAddr_i),
        .o_hz          (w_hz)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RUN:      if (EX_MEM_MemAccess_i && !dmem_ack_i) w_next_state = MEM_WAIT;
            MEM_WAIT: if (dmem_ack_i)                        w_next_state = RUN;
            default:  w_next_state = RUN;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // The ack cycle itself is not held, so the pipeline advances on the same
    // edge that returns the FSM to RUN.
    always_comb begin
        w_req  = 1'b0;
        w_hold = 1'b0;
        case (r_state)
            RUN: begin
                w_req  = EX_MEM_MemAccess_i;
                w_hold = EX_MEM_MemAccess_i && !dmem_ack_i;
            end
            MEM_WAIT: begin
                w_req  = 1'b1;
                w_hold = !dmem_ack_i;
            end
            default: begin
                w_req  = 1'b0;
                w_hold = 1'b0;
            end
        endcase
    end

    // ---------------- wait counter and sticky timeout ----------------
    // wait_cnt counts cycles spent holding for the current access; it
    // saturates so a very long wait cannot wrap below TIMEOUT.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wait_cnt <= 8'd0;
            r_err      <= 1'b0;
        end else begin
            if (w_next_state == RUN) begin
                r_wait_cnt <= 8'd0;
            end else if (r_state == RUN) begin
                r_wait_cnt <= 8'd1;
            end else if (r_wait_cnt != 8'hFF) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end

            if ((r_state == MEM_WAIT) && !dmem_ack_i && (r_wait_cnt >= c_TIMEOUT)) begin
                r_err <= 1'b1;
            end
        end
    end

    // ---------------- stall statistics ----------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= 16'd0;
        end else if (!PC_Write_o && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    // ---------------- priority mux: hold > hz > flush ----------------
    // A taken-branch indication is meaningless while hz is raised because the
    // branch compared stale operands; hz therefore masks the flush.
    assign Pipe_Hold_o     = w_hold;
    assign MEM_WB_Bubble_o = w_hold;
    assign PC_Write_o      = !w_hold && !w_hz;
    assign IF_ID_Write_o   = !w_hold && !w_hz;
    assign ID_EX_Bubble_o  = !w_hold && w_hz;
    assign IF_ID_Flush_o   = !w_hold && !w_hz && (Branch_taken_i || Jump_i);
    assign dmem_req_o      = w_req;
    assign stall_cnt_o     = r_stall_cnt;
    assign err_o           = r_err;

endmodule
`default_nettype wire
